multicast_router: RTL and testbench

MULTICAST_ROUTER -- requirements
Module: multicast_router

---
 rtl/multicast_router.sv | 205 ++++++++++++++++++++
 tb/tb_multicast_router.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicast_router.sv
// -----------------------------------------------------------------------------
// multicast_router
//
// Column router for a PE array. The router accepts bus beats addressed to its
// column (b_tag == id) and splits each beat into up to three per-lane FIFOs
// (ifmap, fltr, psum). The lanes are selected by b_en = {psum, fltr, ifmap}.
// The FIFO heads are presented to the local PE. Results from the PE go back
// to the bus through a one-entry return register.
//
// Parameters
//   DATA_WIDTH : ifmap/fltr word width; psum words are 2*DATA_WIDTH
//   TAG_WIDTH  : column ID / tag width
//   DEPTH      : entries per lane FIFO (power of two, >= 2)
//
// Ports
//   clk, rst                  : rising-edge clock, asynchronous active-high reset
//   id                        : static column ID
//   flush                     : discard all buffered lane data
//   b_valid/b_ready           : bus beat handshake
//   b_tag, b_en               : beat destination tag and lane mask
//   b_ifmap/b_fltr/b_psum     : bus beat data per lane
//   p_*_valid/p_*_ready/p_*   : lane head towards the PE (ifmap, fltr, psum)
//   pe_en                     : PE enable, high while the router is ACTIVE
//   pe_opsum_valid/ready/data : PE result into the return register
//   o_psum_valid/ready/data   : return register towards the bus
//
// Build option
//   MCAST_BROADCAST_EN : when defined, an all-ones b_tag matches every id.
// -----------------------------------------------------------------------------
module multicast_router #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 2,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TAG_WIDTH-1:0]      id,
  input  logic                      flush,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [TAG_WIDTH-1:0]      b_tag,
  input  logic [2:0]                b_en,
  input  logic [DATA_WIDTH-1:0]     b_ifmap,
  input  logic [DATA_WIDTH-1:0]     b_fltr,
  input  logic [2*DATA_WIDTH-1:0]   b_psum,
  output logic                      p_ifmap_valid,
  output logic                      p_fltr_valid,
  output logic                      p_psum_valid,
  input  logic                      p_ifmap_ready,
  input  logic                      p_fltr_ready,
  input  logic                      p_psum_ready,
  output logic [DATA_WIDTH-1:0]     p_ifmap,
  output logic [DATA_WIDTH-1:0]     p_fltr,
  output logic [2*DATA_WIDTH-1:0]   p_psum,
  output logic                      pe_en,
  input  logic                      pe_opsum_valid,
  output logic                      pe_opsum_ready,
  input  logic [2*DATA_WIDTH-1:0]   pe_opsum,
  output logic                      o_psum_valid,
  input  logic                      o_psum_ready,
  output logic [2*DATA_WIDTH-1:0]   o_psum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FLUSH
  } state_t;

  state_t state, state_next;

  // Lane index: 0 = ifmap, 1 = fltr, 2 = psum (same order as b_en).
  logic [2:0]    full;
  logic [2:0]    empty;
  logic [2:0]    push;
  logic [2:0]    pop;
  logic [2:0]    lane_ready;
  logic [AW-1:0] wr_ptr [3];
  logic [AW-1:0] rd_ptr [3];
  logic [CW-1:0] count  [3];

  logic match;
  logic xfer;

`ifdef MCAST_BROADCAST_EN
  assign match = (b_tag == id) || (&b_tag);
`else
  assign match = (b_tag == id);
`endif

  for (genvar g = 0; g < 3; g++) begin : g_lane_flags
    assign full[g]  = (count[g] == CW'(DEPTH));
    assign empty[g] = (count[g] == '0);
  end

  assign lane_ready = {p_psum_ready, p_fltr_ready, p_ifmap_ready};

  // A beat for another column is consumed without effect. A matching beat
  // stalls if any selected lane is full, even when that lane pops this
  // cycle. This keeps the ready path free of the PE-side handshake.
  assign b_ready = (state != ST_FLUSH) && (!match || ((full & b_en) == 3'b000));
  assign xfer    = b_valid && b_ready && match;
  assign push    = {3{xfer}} & b_en;
  assign pop     = ~empty & lane_ready;

  // ---------------------------------------------------------------------------
  // Lane FIFO control. A flush clears every lane. The flush takes priority
  // over a push in the same cycle.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        // Pointers are AW bits wide, so they wrap modulo DEPTH by overflow.
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // NOTE: the storage arrays have no reset. The counts alone decide validity,
  // so the contents of the arrays are never observed before they are written.
  logic [DATA_WIDTH-1:0]   ifmap_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   fltr_mem  [DEPTH];
  logic [2*DATA_WIDTH-1:0] psum_mem  [DEPTH];

  always_ff @(posedge clk) begin
    if (push[0]) ifmap_mem[wr_ptr[0]] <= b_ifmap;
    if (push[1]) fltr_mem[wr_ptr[1]]  <= b_fltr;
    if (push[2]) psum_mem[wr_ptr[2]]  <= b_psum;
  end

  // The head is read from storage, so a pushed word appears the cycle after
  // the push. There is no bypass path for an empty lane.
  assign p_ifmap       = ifmap_mem[rd_ptr[0]];
  assign p_fltr        = fltr_mem[rd_ptr[1]];
  assign p_psum        = psum_mem[rd_ptr[2]];
  assign p_ifmap_valid = !empty[0];
  assign p_fltr_valid  = !empty[1];
  assign p_psum_valid  = !empty[2];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case statement. Every path then
  // assigns it, so no latch is inferred.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_FLUSH;
    end else begin
      case (state)
        ST_IDLE:   if (xfer) state_next = ST_ACTIVE;
        ST_ACTIVE: if ((&empty) && (push == 3'b000) && !o_psum_valid)
                     state_next = ST_IDLE;
        ST_FLUSH:  state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  assign pe_en = (state == ST_ACTIVE);

  // ---------------------------------------------------------------------------
  // Return register. A flush does not clear it, so a finished result is never
  // lost to the bus.
  // ---------------------------------------------------------------------------
  assign pe_opsum_ready = !o_psum_valid || o_psum_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_psum_valid <= 1'b0;
      o_psum       <= '0;
    end else if (pe_opsum_valid && pe_opsum_ready) begin
      o_psum_valid <= 1'b1;
      o_psum       <= pe_opsum;
    end else if (o_psum_ready) begin
      o_psum_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multicast_router.sv
// -----------------------------------------------------------------------------
// tb_multicast_router
//
// Directed testbench for multicast_router with default parameters
// (DATA_WIDTH=16, TAG_WIDTH=2, DEPTH=4). A queue-based reference model
// predicts b_ready, the lane heads, pe_en and the return path. The outputs
// are compared against the model on every falling edge while reset is low.
// Hand-computed literal expectations inside the directed sequence pin the
// model itself.
// -----------------------------------------------------------------------------
module tb_multicast_router;

  localparam int DW    = 16;
  localparam int TW    = 2;
  localparam int DEPTH = 4;

  localparam int M_IDLE   = 0;
  localparam int M_ACTIVE = 1;
  localparam int M_FLUSH  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [TW-1:0]   id;
  logic            flush;
  logic            b_valid;
  logic            b_ready;
  logic [TW-1:0]   b_tag;
  logic [2:0]      b_en;
  logic [DW-1:0]   b_ifmap;
  logic [DW-1:0]   b_fltr;
  logic [2*DW-1:0] b_psum;
  logic            p_ifmap_valid, p_fltr_valid, p_psum_valid;
  logic            p_ifmap_ready, p_fltr_ready, p_psum_ready;
  logic [DW-1:0]   p_ifmap, p_fltr;
  logic [2*DW-1:0] p_psum;
  logic            pe_en;
  logic            pe_opsum_valid, pe_opsum_ready;
  logic [2*DW-1:0] pe_opsum;
  logic            o_psum_valid, o_psum_ready;
  logic [2*DW-1:0] o_psum;

  always #5 clk = ~clk;

  multicast_router #(
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id             (id),
    .flush          (flush),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_tag          (b_tag),
    .b_en           (b_en),
    .b_ifmap        (b_ifmap),
    .b_fltr         (b_fltr),
    .b_psum         (b_psum),
    .p_ifmap_valid  (p_ifmap_valid),
    .p_fltr_valid   (p_fltr_valid),
    .p_psum_valid   (p_psum_valid),
    .p_ifmap_ready  (p_ifmap_ready),
    .p_fltr_ready   (p_fltr_ready),
    .p_psum_ready   (p_psum_ready),
    .p_ifmap        (p_ifmap),
    .p_fltr         (p_fltr),
    .p_psum         (p_psum),
    .pe_en          (pe_en),
    .pe_opsum_valid (pe_opsum_valid),
    .pe_opsum_ready (pe_opsum_ready),
    .pe_opsum       (pe_opsum),
    .o_psum_valid   (o_psum_valid),
    .o_psum_ready   (o_psum_ready),
    .o_psum         (o_psum)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The model state always describes the DUT state that
  // should be visible after the most recent rising edge.
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   m_ifmap [$];
  logic [DW-1:0]   m_fltr  [$];
  logic [2*DW-1:0] m_psum  [$];
  int              m_mode      = M_IDLE;
  logic            m_ret_valid = 1'b0;
  logic [2*DW-1:0] m_ret       = '0;

  function automatic logic m_match();
`ifdef MCAST_BROADCAST_EN
    return (b_tag == id) || (b_tag == 2'b11);
`else
    return (b_tag == id);
`endif
  endfunction

  function automatic logic m_b_ready();
    logic blocked;
    blocked = (b_en[0] && m_ifmap.size() == DEPTH) ||
              (b_en[1] && m_fltr.size()  == DEPTH) ||
              (b_en[2] && m_psum.size()  == DEPTH);
    return (m_mode != M_FLUSH) && (!m_match() || !blocked);
  endfunction

  task automatic model_reset();
    m_ifmap.delete();
    m_fltr.delete();
    m_psum.delete();
    m_mode      = M_IDLE;
    m_ret_valid = 1'b0;
    m_ret       = '0;
  endtask

  // Advance the model by the rising edge that follows the current inputs.
  task automatic model_step();
    logic xfer, any_push, all_empty, ret_ready;
    xfer      = b_valid && m_b_ready() && m_match();
    any_push  = xfer && (b_en != 3'b000);
    all_empty = (m_ifmap.size() == 0) && (m_fltr.size() == 0) && (m_psum.size() == 0);
    ret_ready = !m_ret_valid || o_psum_ready;
    if (flush) begin
      m_ifmap.delete();
      m_fltr.delete();
      m_psum.delete();
      m_mode = M_FLUSH;
    end else begin
      if (m_ifmap.size() > 0 && p_ifmap_ready) void'(m_ifmap.pop_front());
      if (m_fltr.size()  > 0 && p_fltr_ready)  void'(m_fltr.pop_front());
      if (m_psum.size()  > 0 && p_psum_ready)  void'(m_psum.pop_front());
      if (xfer && b_en[0]) m_ifmap.push_back(b_ifmap);
      if (xfer && b_en[1]) m_fltr.push_back(b_fltr);
      if (xfer && b_en[2]) m_psum.push_back(b_psum);
      if (m_mode == M_IDLE && xfer)
        m_mode = M_ACTIVE;
      else if (m_mode == M_ACTIVE && all_empty && !any_push && !m_ret_valid)
        m_mode = M_IDLE;
      else if (m_mode == M_FLUSH)
        m_mode = M_IDLE;
    end
    if (pe_opsum_valid && ret_ready) begin
      m_ret       = pe_opsum;
      m_ret_valid = 1'b1;
    end else if (o_psum_ready) begin
      m_ret_valid = 1'b0;
    end
  endtask

  // Compare on the falling edge. The inputs are stable there and are the same
  // values that the next rising edge samples.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      check("b_ready",        64'(b_ready),        64'(m_b_ready()));
      check("pe_en",          64'(pe_en),          64'(m_mode == M_ACTIVE));
      check("p_ifmap_valid",  64'(p_ifmap_valid),  64'(m_ifmap.size() > 0));
      check("p_fltr_valid",   64'(p_fltr_valid),   64'(m_fltr.size() > 0));
      check("p_psum_valid",   64'(p_psum_valid),   64'(m_psum.size() > 0));
      if (m_ifmap.size() > 0) check("p_ifmap", 64'(p_ifmap), 64'(m_ifmap[0]));
      if (m_fltr.size()  > 0) check("p_fltr",  64'(p_fltr),  64'(m_fltr[0]));
      if (m_psum.size()  > 0) check("p_psum",  64'(p_psum),  64'(m_psum[0]));
      check("pe_opsum_ready", 64'(pe_opsum_ready), 64'(!m_ret_valid || o_psum_ready));
      check("o_psum_valid",   64'(o_psum_valid),   64'(m_ret_valid));
      check("o_psum",         64'(o_psum),         64'(m_ret));
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    id = 2'd1; flush = 1'b0;
    b_valid = 1'b0; b_tag = 2'd0; b_en = 3'b000;
    b_ifmap = '0; b_fltr = '0; b_psum = '0;
    p_ifmap_ready = 1'b0; p_fltr_ready = 1'b0; p_psum_ready = 1'b0;
    pe_opsum_valid = 1'b0; pe_opsum = '0; o_psum_ready = 1'b0;

    // Reset state while rst is held.
    #3;
    check("rst b_ready",        64'(b_ready),        64'd1);
    check("rst pe_opsum_ready", 64'(pe_opsum_ready), 64'd1);
    check("rst p_ifmap_valid",  64'(p_ifmap_valid),  64'd0);
    check("rst p_fltr_valid",   64'(p_fltr_valid),   64'd0);
    check("rst p_psum_valid",   64'(p_psum_valid),   64'd0);
    check("rst pe_en",          64'(pe_en),          64'd0);
    check("rst o_psum_valid",   64'(o_psum_valid),   64'd0);
    check("rst o_psum",         64'(o_psum),         64'd0);
    tick();
    tick();
    rst = 1'b0;

    // A beat tagged for another column is consumed without effect.
    b_valid = 1'b1; b_tag = 2'd2; b_en = 3'b111; b_ifmap = 16'hBEEF;
    #1 check("mismatch b_ready", 64'(b_ready), 64'd1);
    tick();
    b_valid = 1'b0;
    #1;
    check("mismatch pe_en",         64'(pe_en),         64'd0);
    check("mismatch p_ifmap_valid", 64'(p_ifmap_valid), 64'd0);

    // A matching beat on the ifmap and fltr lanes.
    b_valid = 1'b1; b_tag = 2'd1; b_en = 3'b011;
    b_ifmap = 16'h00AA; b_fltr = 16'h0055; b_psum = 32'hCAFE0001;
    tick();
    b_valid = 1'b0;
    #1;
    check("beat p_ifmap_valid", 64'(p_ifmap_valid), 64'd1);
    check("beat p_fltr_valid",  64'(p_fltr_valid),  64'd1);
    check("beat p_psum_valid",  64'(p_psum_valid),  64'd0);
    check("beat pe_en",         64'(pe_en),         64'd1);
    check("beat p_ifmap",       64'(p_ifmap),       64'h00AA);
    check("beat p_fltr",        64'(p_fltr),        64'h0055);
    p_ifmap_ready = 1'b1; p_fltr_ready = 1'b1;
    tick();
    p_ifmap_ready = 1'b0; p_fltr_ready = 1'b0;
    tick();
    #1 check("drained pe_en", 64'(pe_en), 64'd0);

    // Fill the ifmap lane, then stall a fifth beat until a pop makes room.
    b_valid = 1'b1; b_en = 3'b001;
    for (int k = 1; k <= 4; k++) begin
      b_ifmap = 16'(k);
      tick();
    end
    b_ifmap = 16'd5;
    #1 check("full b_ready", 64'(b_ready), 64'd0);
    tick();
    #1;
    check("full b_ready hold", 64'(b_ready), 64'd0);
    check("full head",         64'(p_ifmap), 64'd1);
    p_ifmap_ready = 1'b1;
    #1 check("full pop no pass-through", 64'(b_ready), 64'd0);
    tick();
    p_ifmap_ready = 1'b0;
    #1;
    check("after pop head",    64'(p_ifmap), 64'd2);
    check("after pop b_ready", 64'(b_ready), 64'd1);
    tick();
    b_valid = 1'b0;
    p_ifmap_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      #1 check("drain order", 64'(p_ifmap), 64'(k));
      tick();
    end
    p_ifmap_ready = 1'b0;
    #1 check("drain empty", 64'(p_ifmap_valid), 64'd0);

    // Push and pop in the same cycle on a lane that holds one entry.
    b_valid = 1'b1; b_en = 3'b010; b_fltr = 16'h0011;
    tick();
    b_fltr = 16'h0022; p_fltr_ready = 1'b1;
    tick();
    b_valid = 1'b0; p_fltr_ready = 1'b0;
    #1;
    check("pushpop p_fltr_valid", 64'(p_fltr_valid), 64'd1);
    check("pushpop p_fltr",       64'(p_fltr),       64'h0022);
    p_fltr_ready = 1'b1;
    tick();
    p_fltr_ready = 1'b0;

    // Three beats on all lanes, then a one-cycle flush.
    b_valid = 1'b1; b_en = 3'b111;
    for (int k = 0; k < 3; k++) begin
      b_ifmap = 16'h0100 + 16'(k);
      b_fltr  = 16'h0200 + 16'(k);
      b_psum  = 32'h00030000 + 32'(k);
      tick();
    end
    b_valid = 1'b0;
    #1;
    check("prefl p_psum_valid", 64'(p_psum_valid), 64'd1);
    check("prefl p_psum",       64'(p_psum),       64'h00030000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush b_ready",       64'(b_ready),       64'd0);
    check("flush pe_en",         64'(pe_en),         64'd0);
    check("flush p_ifmap_valid", 64'(p_ifmap_valid), 64'd0);
    check("flush p_fltr_valid",  64'(p_fltr_valid),  64'd0);
    check("flush p_psum_valid",  64'(p_psum_valid),  64'd0);
    tick();
    #1;
    check("postfl b_ready", 64'(b_ready), 64'd1);
    check("postfl pe_en",   64'(pe_en),   64'd0);

    // Return register holds under backpressure, then makes one transfer.
    pe_opsum = 32'h12345678; pe_opsum_valid = 1'b1; o_psum_ready = 1'b0;
    #1 check("ret ready empty", 64'(pe_opsum_ready), 64'd1);
    tick();
    pe_opsum = 32'h0BAD0BAD;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ret hold valid", 64'(o_psum_valid),   64'd1);
      check("ret hold data",  64'(o_psum),         64'h12345678);
      check("ret hold ready", 64'(pe_opsum_ready), 64'd0);
      tick();
    end
    pe_opsum_valid = 1'b0; o_psum_ready = 1'b1;
    #1;
    check("ret release ready", 64'(pe_opsum_ready), 64'd1);
    check("ret release data",  64'(o_psum),         64'h12345678);
    tick();
    #1 check("ret one transfer", 64'(o_psum_valid), 64'd0);
    tick();
    o_psum_ready = 1'b0;

    // Back-to-back results through the return register.
    pe_opsum_valid = 1'b1; o_psum_ready = 1'b1; pe_opsum = 32'hA5A50001;
    tick();
    pe_opsum = 32'hA5A50002;
    tick();
    pe_opsum_valid = 1'b0;
    #1 check("ret b2b data", 64'(o_psum), 64'hA5A50002);
    tick();
    o_psum_ready = 1'b0;

    // An all-ones tag seen by column 0.
    id = 2'd0; b_tag = 2'b11; b_en = 3'b001; b_ifmap = 16'h0077; b_valid = 1'b1;
    #1 check("bcast b_ready", 64'(b_ready), 64'd1);
    tick();
    b_valid = 1'b0;
    #1;
`ifdef MCAST_BROADCAST_EN
    check("bcast p_ifmap_valid", 64'(p_ifmap_valid), 64'd1);
    check("bcast p_ifmap",       64'(p_ifmap),       64'h0077);
`else
    check("bcast p_ifmap_valid", 64'(p_ifmap_valid), 64'd0);
`endif
    p_ifmap_ready = 1'b1;
    tick();
    p_ifmap_ready = 1'b0;
    id = 2'd3; b_ifmap = 16'h0033; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    #1;
    check("id3 p_ifmap_valid", 64'(p_ifmap_valid), 64'd1);
    check("id3 p_ifmap",       64'(p_ifmap),       64'h0033);
    p_ifmap_ready = 1'b1;
    tick();
    p_ifmap_ready = 1'b0;
    tick();

    // Reset in the middle of an operation discards the buffered beat.
    id = 2'd1; b_tag = 2'd1; b_en = 3'b111; b_valid = 1'b1;
    b_ifmap = 16'h0F0F; b_fltr = 16'hF0F0; b_psum = 32'h11112222;
    tick();
    b_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst p_ifmap_valid", 64'(p_ifmap_valid), 64'd0);
    check("midrst pe_en",         64'(pe_en),         64'd0);
    check("midrst o_psum_valid",  64'(o_psum_valid),  64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("postrst p_ifmap_valid", 64'(p_ifmap_valid), 64'd0);
    check("postrst p_fltr_valid",  64'(p_fltr_valid),  64'd0);
    check("postrst p_psum_valid",  64'(p_psum_valid),  64'd0);
    check("postrst pe_en",         64'(pe_en),         64'd0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
